// File: rtl/ascii8_subslot_mapper.sv
// ASCII8 MegaROM bank mapper for one expander subslot: four 8 KB bank registers,
// one-shot write qualifier, combinational ROM decode. Optional macro: ASCII8_MIRROR_EN.
module ascii8_subslot_mapper #(
    parameter int BANK_BITS = 8
) (
    input  logic                   SLT_CLOCK,
    input  logic                   SLT_RESETn,
    input  logic                   EXT_SLTSLn,
    input  logic                   SLT_WEn,
    input  logic                   SLT_RDn,
    input  logic [15:0]            SLT_A,
    input  logic [7:0]             SLT_D,
    output logic [BANK_BITS+12:0]  ROM_A,
    output logic                   ROM_CEn,
    output logic                   ROM_OEn
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q;
    logic [BANK_BITS-1:0] bank_q [4];
    logic [BANK_BITS-1:0] wr_val;
    logic                 wr_hit;
    logic [1:0]           wr_idx;
    logic [1:0]           rd_idx;
    logic                 in_win;

    generate
        if (BANK_BITS <= 8) begin : g_narrow
            assign wr_val = SLT_D[BANK_BITS-1:0];
        end else begin : g_wide
            assign wr_val = {{(BANK_BITS-8){1'b0}}, SLT_D};
        end
    endgenerate

    // 6000h-7FFFh, each 2 KB quarter (and its mirrors) selects one bank register
    assign wr_hit = !EXT_SLTSLn && !SLT_WEn && (SLT_A[15:13] == 3'b011);
    assign wr_idx = SLT_A[12:11];

    // Pages 1/2 map to {0,A13}/{1,A13}; the mirrored pages 0/3 fall out of the same
    // expression, so bank selection never depends on whether mirroring is built in.
    assign rd_idx = {~SLT_A[14], SLT_A[13]};

`ifdef ASCII8_MIRROR_EN
    assign in_win = 1'b1;
`else
    assign in_win = SLT_A[15] ^ SLT_A[14];
`endif

    assign ROM_CEn = !(!EXT_SLTSLn && in_win);
    assign ROM_OEn = !(!ROM_CEn && !SLT_RDn && SLT_WEn);
    assign ROM_A   = {bank_q[rd_idx], SLT_A[12:0]};

    // HOLD blocks further loads until the strobe rises, so wait states commit once
    always_ff @(negedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_hit) begin
                        bank_q[wr_idx] <= wr_val;
                        state_q        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (SLT_WEn) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii8_subslot_mapper.sv
// Directed self-checking bench for ascii8_subslot_mapper (default BANK_BITS=8).
module tb_ascii8_subslot_mapper;

    logic        clk;
    logic        rst_n;
    logic        ext_sltsln;
    logic        wen;
    logic        rdn;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [20:0] rom_a;
    logic        rom_cen;
    logic        rom_oen;

    int checks   = 0;
    int failures = 0;

    ascii8_subslot_mapper #(.BANK_BITS(8)) dut (
        .SLT_CLOCK  (clk),
        .SLT_RESETn (rst_n),
        .EXT_SLTSLn (ext_sltsln),
        .SLT_WEn    (wen),
        .SLT_RDn    (rdn),
        .SLT_A      (addr),
        .SLT_D      (data),
        .ROM_A      (rom_a),
        .ROM_CEn    (rom_cen),
        .ROM_OEn    (rom_oen)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a rising edge; the falling edge in between captures.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; data = d; ext_sltsln = 1'b0; wen = 1'b0;
        @(negedge clk);
        @(posedge clk);
        wen = 1'b1; ext_sltsln = 1'b1;
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] bank);
        addr = a; ext_sltsln = 1'b0; rdn = 1'b0;
        #1;
        chk(tag, {9'd0, rom_cen, rom_oen, rom_a}, {9'd0, 2'b00, bank, a[12:0]});
        @(posedge clk);
        rdn = 1'b1; ext_sltsln = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ext_sltsln = 1'b1; wen = 1'b1; rdn = 1'b1;
        addr = 16'h0000; data = 8'h00;
        #1;
        chk("reset_ce_oe", {30'd0, rom_cen, rom_oen}, {30'd0, 2'b11});
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        bus_read("rst_rd_4000", 16'h4000, 8'h00);
        bus_read("rst_rd_6000", 16'h6000, 8'h00);
        bus_read("rst_rd_8000", 16'h8000, 8'h00);
        bus_read("rst_rd_a000", 16'hA000, 8'h00);

        bus_write(16'h6000, 8'h12);
        bus_write(16'h6800, 8'h34);
        bus_write(16'h7000, 8'h56);
        bus_write(16'h7FFF, 8'h78);
        bus_read("bank0_12", 16'h4000, 8'h12);
        bus_read("bank1_34", 16'h6000, 8'h34);
        bus_read("bank2_56", 16'h8000, 8'h56);
        bus_read("bank3_78", 16'hA000, 8'h78);
        bus_read("bank3_hi_off", 16'hBFFF, 8'h78);

        // Stretched write: data changes during wait states, first value must stick
        addr = 16'h7000; data = 8'h05; ext_sltsln = 1'b0; wen = 1'b0;
        @(negedge clk);
        @(posedge clk);
        data = 8'h09;
        repeat (4) @(negedge clk);
        @(posedge clk);
        wen = 1'b1; ext_sltsln = 1'b1;
        @(negedge clk);
        @(posedge clk);
        bus_read("stretch_bank2", 16'h8000, 8'h05);

        // Both strobes low: write wins, OE stays off
        addr = 16'h4000; ext_sltsln = 1'b0; rdn = 1'b0; wen = 1'b0;
        #1;
        chk("wr_priority", {30'd0, rom_cen, rom_oen}, {30'd0, 2'b01});
        #1;
        wen = 1'b1; rdn = 1'b1; ext_sltsln = 1'b1;
        @(posedge clk);

        bus_write(16'h6800, 8'h0A);
        bus_read("bank1_0a", 16'h6000, 8'h0A);

        // Reset in the middle of a qualified write, released with the write still pending
        addr = 16'h6800; data = 8'h0C; ext_sltsln = 1'b0; wen = 1'b0;
        @(negedge clk);
        #1;
        chk("midwr_load", {24'd0, rom_a[20:13]}, 32'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midwr_async_clr", {24'd0, rom_a[20:13]}, 32'h00);
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midwr_recapture", {24'd0, rom_a[20:13]}, 32'h0C);
        @(posedge clk);
        wen = 1'b1; ext_sltsln = 1'b1;
        @(negedge clk);
        @(posedge clk);
        bus_read("post_rst_bank2", 16'h8000, 8'h00);

        // Unselected subslot: no decode, no register load
        bus_write(16'h6000, 8'h21);
        addr = 16'h6000; data = 8'h3F; ext_sltsln = 1'b1; wen = 1'b0;
        #1;
        chk("unsel_cen", {31'd0, rom_cen}, 32'd1);
        @(negedge clk);
        #1;
        chk("unsel_cen_edge", {31'd0, rom_cen}, 32'd1);
        @(posedge clk);
        wen = 1'b1;
        @(negedge clk);
        @(posedge clk);
        bus_read("unsel_bank0", 16'h4000, 8'h21);

        // Select drops and returns during HOLD with WEn still low: no second load
        addr = 16'h6000; data = 8'h22; ext_sltsln = 1'b0; wen = 1'b0;
        @(negedge clk);
        @(posedge clk);
        ext_sltsln = 1'b1; addr = 16'h7000; data = 8'h33;
        @(negedge clk);
        @(posedge clk);
        ext_sltsln = 1'b0;
        @(negedge clk);
        @(posedge clk);
        wen = 1'b1; ext_sltsln = 1'b1;
        @(negedge clk);
        @(posedge clk);
        bus_read("hold_bank0", 16'h4000, 8'h22);
        bus_read("hold_bank2", 16'h8000, 8'h00);

        bus_write(16'h67FF, 8'h44);
        bus_read("mirror_wr_bank0", 16'h4000, 8'h44);
        bus_write(16'h7800, 8'hFF);
        bus_read("bank3_ff", 16'hBFFF, 8'hFF);
        bus_write(16'h6000, 8'h11);

`ifdef ASCII8_MIRROR_EN
        bus_read("mir_c000", 16'hC000, 8'h11);
        bus_read("mir_0000", 16'h0000, 8'h00);
        bus_read("mir_2000", 16'h2000, 8'hFF);
`else
        addr = 16'hC000; ext_sltsln = 1'b0; rdn = 1'b0;
        #1;
        chk("nomir_c000_cen", {30'd0, rom_cen, rom_oen}, {30'd0, 2'b11});
        addr = 16'h0000;
        #1;
        chk("nomir_0000_cen", {30'd0, rom_cen, rom_oen}, {30'd0, 2'b11});
        @(posedge clk);
        rdn = 1'b1; ext_sltsln = 1'b1;
`endif

        addr = 16'h4000; rdn = 1'b0; ext_sltsln = 1'b1;
        #1;
        chk("unsel_read_cen", {30'd0, rom_cen, rom_oen}, {30'd0, 2'b11});
        rdn = 1'b1;
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
